// File: rtl/booth_pkg.sv
// Shared types and sizing helpers for the sequential Booth multiplier.
// BOOTH_RADIX4_EN selects radix-4 modified Booth; undefined gives radix-2.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // Digit selected by the recoder for one Booth window
  typedef enum logic [2:0] {
    SEL_ZERO,
    SEL_POS_M,
    SEL_POS_2M,
    SEL_NEG_M,
    SEL_NEG_2M
  } booth_sel_e;

`ifdef BOOTH_RADIX4_EN
  localparam bit RADIX4 = 1'b1;
`else
  localparam bit RADIX4 = 1'b0;
`endif

  localparam int unsigned BOOTH_SHIFT = RADIX4 ? 2 : 1;

  function automatic int unsigned booth_ext(input int unsigned width);
    return RADIX4 ? width + 2 : width + 1;
  endfunction

  function automatic int unsigned booth_acc_w(input int unsigned width);
    return RADIX4 ? width + 4 : width + 2;
  endfunction

  function automatic int unsigned booth_iters(input int unsigned width);
    return RADIX4 ? (width + 2) / 2 : width + 1;
  endfunction

  // Radix-4 window {Q[1], Q[0], Q_1}; a radix-2 window {Q[0], Q[0], Q_1}
  // lands on the same table and never selects a 2M digit.
  function automatic booth_sel_e booth_select(input logic [2:0] window);
    booth_sel_e sel;
    case (window)
      3'b001, 3'b010: sel = SEL_POS_M;
      3'b011:         sel = SEL_POS_2M;
      3'b100:         sel = SEL_NEG_2M;
      3'b101, 3'b110: sel = SEL_NEG_M;
      default:        sel = SEL_ZERO;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/booth_mult_seq_if.sv
// Operand/result valid-ready bundle for booth_mult_seq.
interface booth_mult_seq_if #(
  parameter int unsigned WIDTH = 8
);

  logic                 in_valid;
  logic                 in_ready;
  logic                 op_signed;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output in_valid, op_signed, a, b, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, op_signed, a, b, out_ready,
    output in_ready, out_valid, product
  );

endinterface

// File: rtl/booth_recoder.sv
// Combinational Booth digit recoder: window + multiplicand -> accumulator addend.
module booth_recoder
  import booth_pkg::*;
#(
  parameter int unsigned EXT = 9,
  parameter int unsigned AW  = 10
) (
  input  logic [2:0]     window,
  input  logic [EXT-1:0] m,
  output logic [AW-1:0]  addend
);

  logic [AW-1:0] m_ext;
  logic [AW-1:0] m_dbl;
  booth_sel_e    sel;

  assign m_ext = {{(AW-EXT){m[EXT-1]}}, m};
  assign m_dbl = {m_ext[AW-2:0], 1'b0};
  assign sel   = booth_select(window);

  always_comb begin
    addend = '0;
    case (sel)
      SEL_POS_M:  addend = m_ext;
      SEL_POS_2M: addend = m_dbl;
      SEL_NEG_M:  addend = '0 - m_ext;
      SEL_NEG_2M: addend = '0 - m_dbl;
      default:    addend = '0;
    endcase
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Iterative signed/unsigned Booth multiplier with valid/ready on both sides.
// Radix-4 iteration when BOOTH_RADIX4_EN is defined, radix-2 otherwise.
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  booth_mult_seq_if.slave bus
);

  localparam int unsigned EXT   = booth_ext(WIDTH);
  localparam int unsigned AW    = booth_acc_w(WIDTH);
  localparam int unsigned ITERS = booth_iters(WIDTH);
  localparam int unsigned CW    = $clog2(ITERS + 1);
  localparam int unsigned TOT   = AW + EXT + 1;

  if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_width_check
    $error("booth_mult_seq: WIDTH must be even and >= 4");
  end

  state_e             state_q, state_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [EXT-1:0]     q_q, q_d;
  logic               q1_q, q1_d;
  logic [EXT-1:0]     m_q, m_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [2:0]         window;
  logic [AW-1:0]      addend;
  logic [AW-1:0]      acc_sum;
  logic [TOT-1:0]     cat;
  logic [TOT-1:0]     shifted;

  assign window = RADIX4 ? {q_q[1], q_q[0], q1_q} : {q_q[0], q_q[0], q1_q};

  booth_recoder #(
    .EXT (EXT),
    .AW  (AW)
  ) u_recoder (
    .window (window),
    .m      (m_q),
    .addend (addend)
  );

  assign acc_sum = acc_q + addend;
  assign cat     = {acc_sum, q_q, q1_q};
  assign shifted = $signed(cat) >>> BOOTH_SHIFT;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    q_d       = q_q;
    q1_d      = q1_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = RUN;
          acc_d   = '0;
          q1_d    = 1'b0;
          cnt_d   = CW'(ITERS);
          m_d     = bus.op_signed ? {{(EXT-WIDTH){bus.a[WIDTH-1]}}, bus.a}
                                  : {{(EXT-WIDTH){1'b0}}, bus.a};
          q_d     = bus.op_signed ? {{(EXT-WIDTH){bus.b[WIDTH-1]}}, bus.b}
                                  : {{(EXT-WIDTH){1'b0}}, bus.b};
        end
      end
      RUN: begin
        acc_d = shifted[TOT-1 -: AW];
        q_d   = shifted[EXT:1];
        q1_d  = shifted[0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          product_d = shifted[2*WIDTH:1];
          state_d   = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      m_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      q1_q      <= q1_d;
      m_q       <= m_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.product   = product_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed and randomised self-checking bench for booth_mult_seq at WIDTH=8.
module tb_booth_mult_seq;

  localparam int unsigned W     = 8;
  localparam int unsigned N_RND = 1000;
`ifdef BOOTH_RADIX4_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 9;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  booth_mult_seq_if #(.WIDTH(W)) bus ();

  booth_mult_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [15:0] ref_mul(input logic sgn, input logic [7:0] x, input logic [7:0] y);
    int p;
    if (sgn) p = int'($signed(x)) * int'($signed(y));
    else     p = int'(x) * int'(y);
    return p[15:0];
  endfunction

  task automatic issue(input string tag, input logic sgn, input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.op_signed = sgn;
    bus.a         = x;
    bus.b         = y;
    @(negedge clk);
    bus.in_valid  = 1'b0;
  endtask

  task automatic wait_done(output int k);
    k = 0;
    while (!bus.out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic consume(input string tag);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_idle"}, {30'd0, bus.out_valid, bus.in_ready}, 32'b01);
  endtask

  task automatic run_mul(input string tag, input logic sgn, input logic [7:0] x,
                         input logic [7:0] y, input logic [15:0] exp);
    int k;
    issue(tag, sgn, x, y);
    wait_done(k);
    check({tag, "_lat"}, 32'(k), 32'(LAT));
    check({tag, "_prod"}, 32'(bus.product), 32'(exp));
    consume(tag);
  endtask

  initial begin
    int k;
    int issued, got, cyc;
    logic [15:0] sb[$];
    logic [7:0]  ra, rb;
    logic        rs;

    bus.in_valid  = 1'b0;
    bus.op_signed = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("reset_outputs", {bus.in_ready, bus.out_valid, 16'(bus.product)}, {1'b1, 1'b0, 16'h0000});
    rst_n = 1'b1;

    run_mul("s_m3x5",    1'b1, 8'hFD, 8'h05, 16'hFFF1);
    run_mul("u_ffxff",   1'b0, 8'hFF, 8'hFF, 16'hFE01);
    run_mul("s_ffxff",   1'b1, 8'hFF, 8'hFF, 16'h0001);
    run_mul("s_80x80",   1'b1, 8'h80, 8'h80, 16'h4000);
    run_mul("u_80x80",   1'b0, 8'h80, 8'h80, 16'h4000);
    run_mul("s_80x7f",   1'b1, 8'h80, 8'h7F, 16'hC080);
    run_mul("s_7fx7f",   1'b1, 8'h7F, 8'h7F, 16'h3F01);
    run_mul("u_05xfd",   1'b0, 8'h05, 8'hFD, 16'h04F1);
    run_mul("s_00x80",   1'b1, 8'h00, 8'h80, 16'h0000);

    // Backpressure with in_valid noise during RUN and DONE
    issue("bp", 1'b1, 8'h0B, 8'h0D);
    bus.in_valid  = 1'b1;
    bus.op_signed = 1'b0;
    bus.a         = 8'hFF;
    bus.b         = 8'hFF;
    wait_done(k);
    check("bp_lat", 32'(k), 32'(LAT));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("bp_hold", {bus.out_valid, bus.in_ready, 16'(bus.product)}, {1'b1, 1'b0, 16'h008F});
    end
    bus.in_valid = 1'b0;
    consume("bp");
    @(negedge clk);
    check("bp_no_requeue", {bus.in_ready, bus.out_valid}, 2'b10);

    // Asynchronous reset in the middle of a run
    issue("rst", 1'b0, 8'h12, 8'h34);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_run", {bus.in_ready, bus.out_valid, 16'(bus.product)}, {1'b1, 1'b0, 16'h0000});
    @(negedge clk);
    rst_n = 1'b1;
    run_mul("u_7x9", 1'b0, 8'd7, 8'd9, 16'd63);

    // Randomised back-to-back traffic with random consumer stalls
    issued = 0;
    got    = 0;
    cyc    = 0;
    while ((issued < int'(N_RND) || got < issued) && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      bus.out_ready = 1'($urandom_range(0, 1));
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) check("rnd_spurious", 32'(got + 1), 32'(issued));
        else begin
          check("rnd_prod", 32'(bus.product), 32'(sb.pop_front()));
          got++;
        end
      end
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: ra = 8'h80;
        1: rb = 8'hFF;
        2: begin ra = 8'h80; rb = 8'h80; end
        default: ;
      endcase
      bus.op_signed = rs;
      bus.a         = ra;
      bus.b         = rb;
      if (bus.in_ready && issued < int'(N_RND) && $urandom_range(0, 2) != 0) begin
        bus.in_valid = 1'b1;
        sb.push_back(ref_mul(rs, ra, rb));
        issued++;
      end else begin
        bus.in_valid = !bus.in_ready && ($urandom_range(0, 1) == 1);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("rnd_issued", 32'(issued), 32'(N_RND));
    check("rnd_results", 32'(got), 32'(N_RND));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
